ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of ALU result, store data and branch target.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  hold all registered state this cycle.
REQ-005 flush  input  1  replace captured stage contents with a bubble.
REQ-006 ex_valid  input  1  EX-stage instruction is real (not a bubble).
REQ-007 alu_result  input  WIDTH  result assembled from the 1-bit ALU slice chain.
REQ-008 alu_zero  input  1  ALU result equals zero.
REQ-009 alu_overflow  input  1  signed overflow from the MSB slice.
REQ-010 ovf_en  input  1  instruction traps on overflow (add/sub vs addu/subu).
REQ-011 ex_rt_data  input  WIDTH  store data.
REQ-012 ex_branch_target  input  WIDTH  computed branch address.
REQ-013 ex_dest  input  5  destination register number.
REQ-014 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  input  1 each  control bits.
REQ-015 mem_valid  output  1  registered valid.
REQ-016 mem_alu_result, mem_rt_data, mem_branch_target  output  WIDTH each  registered copies.
REQ-017 mem_dest  output  5  registered destination.
REQ-018 mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  output  1 each  qualified control.
REQ-019 mem_pc_src  output  1  registered branch-taken.
REQ-020 mem_ovf_trap  output  1  registered overflow exception flag.

Function
REQ-021 Latency: exactly one clock from EX inputs to mem_* outputs; no combinational path input to output.
REQ-022 Priority per edge: flush > stall > normal capture.
REQ-023 Normal capture: all data fields load from inputs; mem_valid <= ex_valid.
REQ-024 Trap = ex_valid & ovf_en & alu_overflow; mem_ovf_trap <= trap.
REQ-025 mem_reg_write <= ex_valid & ex_reg_write & ~trap & (ex_dest != 0).
REQ-026 mem_mem_write <= ex_valid & ex_mem_write & ~trap; mem_mem_read <= ex_valid & ex_mem_read & ~trap.
REQ-027 mem_mem_to_reg <= ex_valid & ex_mem_to_reg.
REQ-028 mem_pc_src <= ex_valid & ex_branch & alu_zero & ~trap.
REQ-029 Stall (flush low): every output register holds its previous value, including mem_ovf_trap and mem_pc_src.
REQ-030 Flush: mem_valid, all control outputs, mem_pc_src, mem_ovf_trap <= 0; data fields (result, rt_data, target, dest) may hold any value but implementation loads zero.
REQ-031 Flush and stall together: flush behaviour of REQ-030 applies.
REQ-032 ex_valid low with no flush/stall: captured as bubble; control outputs 0, data fields loaded normally.
REQ-033 No arithmetic in this block beyond the trap/qualify logic; widths passed through unchanged.

Reset
REQ-034 rst_n low asynchronously forces every output to 0 (mem_valid, all WIDTH fields, mem_dest, controls, mem_pc_src, mem_ovf_trap) without a clock edge.
REQ-035 Reset deassertion mid-stream: first rising edge after rst_n high performs normal capture per REQ-022.

Verification
REQ-036 Reset: drive nonzero inputs, pulse rst_n low between edges -> all outputs 0 immediately, before next edge.
REQ-037 Capture: ex_valid=1, ex_reg_write=1, ex_dest=5, alu_result=0x0000_1234 -> next edge mem_reg_write=1, mem_dest=5, mem_alu_result=0x0000_1234, mem_valid=1.
REQ-038 Overflow trap: ex_valid=1, ovf_en=1, alu_overflow=1, ex_reg_write=1, ex_mem_write=1 -> mem_ovf_trap=1, mem_reg_write=0, mem_mem_write=0; repeat with ovf_en=0 -> trap 0, writes 1.
REQ-039 Branch/$zero: ex_branch=1, alu_zero=1 -> mem_pc_src=1; ex_dest=0 with ex_reg_write=1 -> mem_reg_write=0.
REQ-040 Stall then flush: capture result 0xDEAD_BEEF, assert stall 3 cycles with changing inputs -> outputs hold 0xDEAD_BEEF; assert stall+flush -> mem_valid=0, all controls 0 next edge.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Captures the execute-stage result, store data, branch target and destination
// one clock after EX. Control bits are qualified with valid, with the overflow
// trap and with the $zero destination before they are stored, so MEM only ever
// sees actions that are allowed to happen. Flush inserts a bubble and takes
// priority over stall. Stall holds every register, including the trap and
// branch-taken flags.
module ex_mem_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             ovf_en,
  input  logic [WIDTH-1:0] ex_rt_data,
  input  logic [WIDTH-1:0] ex_branch_target,
  input  logic [4:0]       ex_dest,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_mem_to_reg,
  input  logic             ex_branch,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_alu_result,
  output logic [WIDTH-1:0] mem_rt_data,
  output logic [WIDTH-1:0] mem_branch_target,
  output logic [4:0]       mem_dest,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_mem_to_reg,
  output logic             mem_pc_src,
  output logic             mem_ovf_trap
);

  // Qualified next-state control values
  logic trap_s;
  logic reg_write_s;
  logic mem_read_s;
  logic mem_write_s;
  logic mem_to_reg_s;
  logic pc_src_s;

  // Stored stage contents
  logic             valid_r;
  logic [WIDTH-1:0] alu_result_r;
  logic [WIDTH-1:0] rt_data_r;
  logic [WIDTH-1:0] branch_target_r;
  logic [4:0]       dest_r;
  logic             reg_write_r;
  logic             mem_read_r;
  logic             mem_write_r;
  logic             mem_to_reg_r;
  logic             pc_src_r;
  logic             ovf_trap_r;

  // Trap detection and control qualification; a trapping instruction must not
  // write the register file or memory, and writes to $zero are dropped here.
  always_comb begin
    trap_s       = ex_valid & ovf_en & alu_overflow;
    reg_write_s  = ex_valid & ex_reg_write & ~trap_s & (ex_dest != 5'd0);
    mem_read_s   = ex_valid & ex_mem_read & ~trap_s;
    mem_write_s  = ex_valid & ex_mem_write & ~trap_s;
    mem_to_reg_s = ex_valid & ex_mem_to_reg;
    pc_src_s     = ex_valid & ex_branch & alu_zero & ~trap_s;
  end

  // Stage register: async reset, then flush beats stall beats capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r         <= 1'b0;
      alu_result_r    <= {WIDTH{1'b0}};
      rt_data_r       <= {WIDTH{1'b0}};
      branch_target_r <= {WIDTH{1'b0}};
      dest_r          <= 5'd0;
      reg_write_r     <= 1'b0;
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_to_reg_r    <= 1'b0;
      pc_src_r        <= 1'b0;
      ovf_trap_r      <= 1'b0;
    end else if (flush) begin
      valid_r         <= 1'b0;
      alu_result_r    <= {WIDTH{1'b0}};
      rt_data_r       <= {WIDTH{1'b0}};
      branch_target_r <= {WIDTH{1'b0}};
      dest_r          <= 5'd0;
      reg_write_r     <= 1'b0;
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_to_reg_r    <= 1'b0;
      pc_src_r        <= 1'b0;
      ovf_trap_r      <= 1'b0;
    end else if (!stall) begin
      valid_r         <= ex_valid;
      alu_result_r    <= alu_result;
      rt_data_r       <= ex_rt_data;
      branch_target_r <= ex_branch_target;
      dest_r          <= ex_dest;
      reg_write_r     <= reg_write_s;
      mem_read_r      <= mem_read_s;
      mem_write_r     <= mem_write_s;
      mem_to_reg_r    <= mem_to_reg_s;
      pc_src_r        <= pc_src_s;
      ovf_trap_r      <= trap_s;
    end else begin
      valid_r         <= valid_r;
      alu_result_r    <= alu_result_r;
      rt_data_r       <= rt_data_r;
      branch_target_r <= branch_target_r;
      dest_r          <= dest_r;
      reg_write_r     <= reg_write_r;
      mem_read_r      <= mem_read_r;
      mem_write_r     <= mem_write_r;
      mem_to_reg_r    <= mem_to_reg_r;
      pc_src_r        <= pc_src_r;
      ovf_trap_r      <= ovf_trap_r;
    end
  end

  assign mem_valid         = valid_r;
  assign mem_alu_result    = alu_result_r;
  assign mem_rt_data       = rt_data_r;
  assign mem_branch_target = branch_target_r;
  assign mem_dest          = dest_r;
  assign mem_reg_write     = reg_write_r;
  assign mem_mem_read      = mem_read_r;
  assign mem_mem_write     = mem_write_r;
  assign mem_mem_to_reg    = mem_to_reg_r;
  assign mem_pc_src        = pc_src_r;
  assign mem_ovf_trap      = ovf_trap_r;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: a behavioural model of the stage plus
// directed vectors with literal expectations.
module tb_ex_mem_reg;

  localparam int W = 32;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] res;
    logic [W-1:0] rt;
    logic [W-1:0] tgt;
    logic [4:0]   dest;
    logic         rw;
    logic         mr;
    logic         mw;
    logic         m2r;
    logic         pcs;
    logic         trap;
  } out_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic         ex_valid = 1'b0;
  logic [W-1:0] alu_result = '0;
  logic         alu_zero = 1'b0;
  logic         alu_overflow = 1'b0;
  logic         ovf_en = 1'b0;
  logic [W-1:0] ex_rt_data = '0;
  logic [W-1:0] ex_branch_target = '0;
  logic [4:0]   ex_dest = 5'd0;
  logic         ex_reg_write = 1'b0;
  logic         ex_mem_read = 1'b0;
  logic         ex_mem_write = 1'b0;
  logic         ex_mem_to_reg = 1'b0;
  logic         ex_branch = 1'b0;

  logic         mem_valid;
  logic [W-1:0] mem_alu_result;
  logic [W-1:0] mem_rt_data;
  logic [W-1:0] mem_branch_target;
  logic [4:0]   mem_dest;
  logic         mem_reg_write;
  logic         mem_mem_read;
  logic         mem_mem_write;
  logic         mem_mem_to_reg;
  logic         mem_pc_src;
  logic         mem_ovf_trap;

  int pass_cnt = 0;
  int total_cnt = 0;

  out_t dut_o;
  out_t exp_o = '0;

  ex_mem_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .ovf_en(ovf_en), .ex_rt_data(ex_rt_data),
    .ex_branch_target(ex_branch_target), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_rt_data(mem_rt_data), .mem_branch_target(mem_branch_target),
    .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_pc_src(mem_pc_src),
    .mem_ovf_trap(mem_ovf_trap)
  );

  assign dut_o = '{valid: mem_valid, res: mem_alu_result, rt: mem_rt_data,
                   tgt: mem_branch_target, dest: mem_dest, rw: mem_reg_write,
                   mr: mem_mem_read, mw: mem_mem_write, m2r: mem_mem_to_reg,
                   pcs: mem_pc_src, trap: mem_ovf_trap};

  always #5 clk = ~clk;

  // What the MEM stage should hold after capturing the current EX inputs
  function automatic out_t captured();
    out_t o;
    logic t;
    t      = ex_valid && ovf_en && alu_overflow;
    o      = '0;
    o.valid = ex_valid;
    o.res  = alu_result;
    o.rt   = ex_rt_data;
    o.tgt  = ex_branch_target;
    o.dest = ex_dest;
    if (ex_valid && !t) begin
      o.rw  = ex_reg_write && (ex_dest != 5'd0);
      o.mr  = ex_mem_read;
      o.mw  = ex_mem_write;
      o.pcs = ex_branch && alu_zero;
    end
    o.m2r  = ex_valid && ex_mem_to_reg;
    o.trap = t;
    return o;
  endfunction

  // Reference model of the stage contents
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      exp_o = '0;
    else if (flush)  exp_o = '0;
    else if (!stall) exp_o = captured();
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic check_o(input string name, input out_t act, input out_t req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Whole-output comparison against the model on every falling edge
  always @(negedge clk) check_o("model", dut_o, exp_o);

  task automatic clear_in();
    ex_valid = 1'b0; alu_result = '0; alu_zero = 1'b0; alu_overflow = 1'b0;
    ovf_en = 1'b0; ex_rt_data = '0; ex_branch_target = '0; ex_dest = 5'd0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_mem_to_reg = 1'b0; ex_branch = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    #2;
    check_o("reset_zero", dut_o, '0);
    step(); step();
    rst_n = 1'b1;

    // Capture
    clear_in();
    ex_valid = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd5; alu_result = 32'h0000_1234;
    ex_rt_data = 32'h0000_00AA; ex_branch_target = 32'h0000_4000;
    step();
    check("cap_rw", {31'd0, mem_reg_write}, 32'd1);
    check("cap_dest", {27'd0, mem_dest}, 32'd5);
    check("cap_res", mem_alu_result, 32'h0000_1234);
    check("cap_valid", {31'd0, mem_valid}, 32'd1);

    // Overflow trap, then same with trapping disabled
    clear_in();
    ex_valid = 1'b1; ovf_en = 1'b1; alu_overflow = 1'b1; ex_reg_write = 1'b1;
    ex_mem_write = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd3; ex_branch = 1'b1; alu_zero = 1'b1;
    step();
    check("trap_flag", {31'd0, mem_ovf_trap}, 32'd1);
    check("trap_rw", {31'd0, mem_reg_write}, 32'd0);
    check("trap_mw", {31'd0, mem_mem_write}, 32'd0);
    check("trap_pcs", {31'd0, mem_pc_src}, 32'd0);
    ovf_en = 1'b0;
    step();
    check("notrap_flag", {31'd0, mem_ovf_trap}, 32'd0);
    check("notrap_rw", {31'd0, mem_reg_write}, 32'd1);
    check("notrap_mw", {31'd0, mem_mem_write}, 32'd1);

    // Branch taken and $zero destination
    clear_in();
    ex_valid = 1'b1; ex_branch = 1'b1; alu_zero = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd0;
    ex_branch_target = 32'h0040_0010;
    step();
    check("br_pcs", {31'd0, mem_pc_src}, 32'd1);
    check("zero_rw", {31'd0, mem_reg_write}, 32'd0);
    check("br_tgt", mem_branch_target, 32'h0040_0010);
    alu_zero = 1'b0;
    step();
    check("br_nt_pcs", {31'd0, mem_pc_src}, 32'd0);

    // Bubble: data passes, controls do not
    clear_in();
    alu_result = 32'h0000_ABCD; ex_reg_write = 1'b1; ex_mem_write = 1'b1; ex_mem_to_reg = 1'b1;
    ex_dest = 5'd7; ex_branch = 1'b1; alu_zero = 1'b1; ovf_en = 1'b1; alu_overflow = 1'b1;
    step();
    check("bub_valid", {31'd0, mem_valid}, 32'd0);
    check("bub_res", mem_alu_result, 32'h0000_ABCD);
    check("bub_m2r", {31'd0, mem_mem_to_reg}, 32'd0);
    check("bub_trap", {31'd0, mem_ovf_trap}, 32'd0);

    // Stall hold, then stall together with flush
    clear_in();
    ex_valid = 1'b1; alu_result = 32'hDEAD_BEEF; ex_reg_write = 1'b1; ex_dest = 5'd9;
    ovf_en = 1'b1; alu_overflow = 1'b1;
    step();
    check("pre_stall_trap", {31'd0, mem_ovf_trap}, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_result = 32'h1000_0000 + 32'(i); ovf_en = 1'b0; ex_dest = 5'd10 + 5'(i);
      step();
      check("stall_res", mem_alu_result, 32'hDEAD_BEEF);
      check("stall_trap", {31'd0, mem_ovf_trap}, 32'd1);
    end
    flush = 1'b1;
    step();
    check("flush_valid", {31'd0, mem_valid}, 32'd0);
    check("flush_trap", {31'd0, mem_ovf_trap}, 32'd0);
    check("flush_res", mem_alu_result, 32'h0000_0000);

    // Flush alone over a valid instruction
    clear_in();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_to_reg = 1'b1; ex_dest = 5'd4;
    alu_result = 32'h0000_0100;
    step();
    check("load_mr", {31'd0, mem_mem_read}, 32'd1);
    check("load_m2r", {31'd0, mem_mem_to_reg}, 32'd1);
    flush = 1'b1;
    step();
    check("flush2_mr", {31'd0, mem_mem_read}, 32'd0);

    // Asynchronous reset mid-stream, then first edge captures normally
    clear_in();
    ex_valid = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd12; alu_result = 32'h5555_0001;
    ex_rt_data = 32'h7777_0002;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_o("async_reset", dut_o, '0);
    step();
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_valid", {31'd0, mem_valid}, 32'd1);
    check("post_rst_rt", mem_rt_data, 32'h7777_0002);

    clear_in();
    step(); step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
